// File: rtl/icache_direct_if.sv
// icache_direct_if: bundles the CPU fetch channel, the burst memory port and
// the optional performance counters of icache_direct.
// master = the environment (CPU + memory); slave = the cache.
interface icache_direct_if;
  // CPU instruction channel
  logic [31:0] i_addr;
  logic        i_read;
  logic [31:0] i_rdata;
  logic        i_resp;
  // Burst physical-memory port
  logic [31:0] pmem_addr;
  logic        pmem_read;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  // Performance counters (constant 0 unless ICACHE_PERF_CTR_EN)
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output i_addr, i_read, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, pmem_addr, pmem_read, hit_count, miss_count
  );

  modport slave (
    input  i_addr, i_read, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, pmem_addr, pmem_read, hit_count, miss_count
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: read-only direct-mapped instruction cache.
// Hits answer combinationally; a miss fetches a 32-byte line as four 64-bit
// beats, installs it in one cycle and the retried lookup then hits.
// Optional feature macro: ICACHE_PERF_CTR_EN (hit/miss counters).
// Reset input rst is asynchronous and active-low.
module icache_direct #(
  parameter int NUM_SETS = 16
) (
  input logic            clk,
  input logic            rst,
  icache_direct_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_INSTALL = 2'd2;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [1:0]          beat_q;
  logic [26:0]         line_q;     // latched line number (address bits [31:5])
  logic [255:0]        buf_q;      // line assembled from the four beats
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [255:0]        data_q [NUM_SETS];

  // Lookup fields of the current fetch address
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  assign idx  = bus.i_addr[4+IDX_W:5];
  assign tag  = bus.i_addr[31:5+IDX_W];
  assign word = bus.i_addr[4:2];

  // Byte offset bits never matter for an aligned instruction fetch
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.i_addr[1:0];

  // Set and tag the pending fill will be installed under
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[26:IDX_W];

  logic hit;
  logic miss_start;
  logic beat_take;
  logic last_beat;
  assign hit        = (state_q == ST_IDLE) && bus.i_read && valid_q[idx] && (tag_q[idx] == tag);
  assign miss_start = (state_q == ST_IDLE) && bus.i_read && !hit;
  assign beat_take  = (state_q == ST_FILL) && bus.pmem_resp;
  assign last_beat  = beat_take && (beat_q == 2'd3);

  assign bus.i_resp    = hit;
  assign bus.i_rdata   = data_q[idx][{word, 5'b0} +: 32];
  assign bus.pmem_read = (state_q == ST_FILL);
  assign bus.pmem_addr = {line_q, 5'b0};

  // Next-state selection: IDLE -> FILL on miss, FILL -> INSTALL on 4th beat
  always_comb begin
    // NOTE: default assignment first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (miss_start) state_d = ST_FILL;
      ST_FILL:    if (last_beat)  state_d = ST_INSTALL;
      ST_INSTALL: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, beat counter and the latched line address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (beat_take) beat_q <= beat_q + 2'd1;  // wraps 3 -> 0 on the 4th beat
      if (miss_start) line_q <= bus.i_addr[31:5];
    end
  end

  // Beat buffer: beat k lands in bits [64k+63:64k]
  always_ff @(posedge clk) begin
    if (beat_take) buf_q[{beat_q, 6'b0} +: 64] <= bus.pmem_rdata;
  end

  // Valid bits: cleared by reset, set only when a complete line is installed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (state_q == ST_INSTALL) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: overwritten on install, whatever the set held before
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are not reset; a cleared valid bit already makes their contents unobservable.
    if (state_q == ST_INSTALL) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= buf_q;
    end
  end

`ifdef ICACHE_PERF_CTR_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Performance counters: hits per responding cycle, misses per burst started
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed test of icache_direct against a line-level
// model (which lines are resident, whether a burst is outstanding) checked
// every cycle, plus literal expectations taken from the documented scenarios.
module tb_icache_direct;

  localparam int NUM_SETS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  icache_direct_if bus ();

  icache_direct #(.NUM_SETS(NUM_SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory: line 0x60 holds 0x0000_0000 .. 0x7777_7777, others a pattern
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h3) return 32'h1111_1111 * {29'd0, a[4:2]};
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] exp_counter(input logic [31:0] v);
`ifdef ICACHE_PERF_CTR_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // ---------------- memory responder ----------------
  bit spurious  = 1'b0;  // drive pmem_resp while no burst is requested
  bit gap_mode  = 1'b0;  // insert an idle cycle between beats
  int beat_idx  = -1;    // index of the beat currently on the bus
  bit mem_active;
  bit mem_phase;
  int mem_cnt;

  initial begin : responder
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    mem_active     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_active    = 1'b0;
        bus.pmem_resp = 1'b0;
        beat_idx      = -1;
      end else if (bus.pmem_read) begin
        if (!mem_active) begin
          mem_active    = 1'b1;
          mem_cnt       = 0;
          mem_phase     = 1'b0;
          bus.pmem_resp = 1'b0;
        end else if (mem_cnt >= 4 || (gap_mode && !mem_phase)) begin
          bus.pmem_resp = 1'b0;
          mem_phase     = 1'b1;
        end else begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = {mem_word(bus.pmem_addr + 32'(8 * mem_cnt + 4)),
                            mem_word(bus.pmem_addr + 32'(8 * mem_cnt))};
          beat_idx       = mem_cnt;
          mem_cnt++;
          mem_phase      = 1'b0;
        end
      end else begin
        mem_active     = 1'b0;
        beat_idx       = -1;
        bus.pmem_resp  = spurious;
        bus.pmem_rdata = 64'hDEAD_BEEF_BAD0_BAD0;
      end
    end
  end

  // ---------------- line-level model + per-cycle compare ----------------
  bit          m_valid [NUM_SETS];
  logic [26:0] m_line  [NUM_SETS];
  bit          m_busy;       // burst requested and not yet fully delivered
  bit          m_install;    // one cycle of installation after the 4th beat
  int          m_beats;
  logic [26:0] m_fill_line;
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  bit          m_hit;
  int          m_set;
  int          bursts;
  bit          prev_pmem_read;

  initial begin : compare
    bursts = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_i_resp", bus.i_resp, 0);
        check("reset_pmem_read", bus.pmem_read, 0);
        check("reset_pmem_addr", bus.pmem_addr, 0);
        check("reset_hit_count", bus.hit_count, 0);
        check("reset_miss_count", bus.miss_count, 0);
        for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 1'b0;
        m_busy = 1'b0; m_install = 1'b0; m_beats = 0;
        m_hits = '0; m_misses = '0; prev_pmem_read = 1'b0;
      end else begin
        m_set = int'(bus.i_addr[31:5]) % NUM_SETS;
        m_hit = !m_busy && !m_install && bus.i_read && m_valid[m_set] &&
                (m_line[m_set] == bus.i_addr[31:5]);
        check("cmp_i_resp", bus.i_resp, m_hit);
        if (m_hit) check("cmp_i_rdata", bus.i_rdata, mem_word({bus.i_addr[31:2], 2'b00}));
        check("cmp_pmem_read", bus.pmem_read, m_busy);
        if (m_busy) check("cmp_pmem_addr", bus.pmem_addr, {m_fill_line, 5'b0});
        check("cmp_hit_count", bus.hit_count, exp_counter(m_hits));
        check("cmp_miss_count", bus.miss_count, exp_counter(m_misses));
        // advance the model by one cycle
        if (m_hit) m_hits++;
        if (m_install) begin
          m_valid[int'(m_fill_line) % NUM_SETS] = 1'b1;
          m_line[int'(m_fill_line) % NUM_SETS]  = m_fill_line;
          m_install = 1'b0;
        end else if (m_busy) begin
          if (bus.pmem_resp) begin
            m_beats++;
            if (m_beats == 4) begin
              m_busy    = 1'b0;
              m_install = 1'b1;
            end
          end
        end else if (bus.i_read && !m_hit) begin
          m_busy      = 1'b1;
          m_beats     = 0;
          m_fill_line = bus.i_addr[31:5];
          m_misses++;
        end
        if (bus.pmem_read && !prev_pmem_read) bursts++;
        prev_pmem_read = bus.pmem_read;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Present addr at the start of a cycle; n = cycles until i_resp (0 = hit)
  task automatic fetch(input logic [31:0] addr, output int n);
    @(posedge clk);
    #1;
    bus.i_addr = addr;
    bus.i_read = 1'b1;
    #1;
    n = 0;
    while (!bus.i_resp && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("fetch_responds", bus.i_resp, 1);
  endtask

  // Wait until beat k is on the bus (bounded)
  task automatic wait_beat(input int k, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (bus.pmem_resp && beat_idx == k) seen = 1'b1;
    end
  endtask

  int n;
  bit seen;

  initial begin : stimulus
    bus.i_addr = '0;
    bus.i_read = 1'b0;
    #12;
    check("lit_reset_resp", bus.i_resp, 0);
    check("lit_reset_pmem_read", bus.pmem_read, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Cold miss on 0x64
    @(posedge clk);
    #1;
    bus.i_addr = 32'h0000_0064;
    bus.i_read = 1'b1;
    #1;
    check("cold_no_resp", bus.i_resp, 0);
    @(posedge clk);
    #2;
    check("cold_pmem_read", bus.pmem_read, 1);
    check("cold_pmem_addr", bus.pmem_addr, 32'h0000_0060);
    n = 1;
    while (!bus.i_resp && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("cold_latency", n, 7);
    check("cold_rdata", bus.i_rdata, 32'h1111_1111);

    // Hit on the same line, same cycle
    bus.i_addr = 32'h0000_007C;
    #1;
    check("hit_resp", bus.i_resp, 1);
    check("hit_rdata", bus.i_rdata, 32'h7777_7777);
    check("hit_no_pmem_read", bus.pmem_read, 0);
    @(posedge clk);
    #2;
    check("hit_still_no_burst", bus.pmem_read, 0);

    // Conflict eviction: 0x60 / 0x260 / 0x60 share set 3
    fetch(32'h0000_0060, n);
    check("conflict_60_hits", n, 0);
    check("conflict_60_rdata", bus.i_rdata, 32'h0000_0000);
    gap_mode = 1'b1;
    fetch(32'h0000_0260, n);
    gap_mode = 1'b0;
    check("gap_latency_gt7", n > 7, 1);
    check("conflict_260_rdata", bus.i_rdata, 32'h0260_FD9F);
    fetch(32'h0000_0060, n);
    check("evict_refetch_latency", n, 7);
    check("bursts_after_conflict", bursts, 3);
    check("lit_miss_count_3", bus.miss_count, exp_counter(32'd3));

    // Address change mid-fill: 0x100 is still installed, then 0x200 misses
    @(posedge clk);
    #1;
    bus.i_addr = 32'h0000_0100;
    wait_beat(2, seen);
    check("midfill_beat2_seen", seen, 1);
    bus.i_addr = 32'h0000_0200;
    n = 0;
    while (!bus.i_resp && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("midfill_200_resp", bus.i_resp, 1);
    check("midfill_200_rdata", bus.i_rdata, 32'h0200_FDFF);
    check("bursts_after_midfill", bursts, 5);
    fetch(32'h0000_0100, n);
    check("installed_100_hit", n, 0);
    check("installed_100_rdata", bus.i_rdata, 32'h0100_FEFF);

    // Reset mid-fill after beat 1
    @(posedge clk);
    #1;
    bus.i_addr = 32'h0000_0400;
    wait_beat(1, seen);
    check("reset_beat1_seen", seen, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midfill_reset_pmem_read", bus.pmem_read, 0);
    check("midfill_reset_pmem_addr", bus.pmem_addr, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n = 0;
    while (!bus.i_resp && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reset_refill_latency", n, 7);
    check("reset_refill_rdata", bus.i_rdata, 32'h0400_FBFF);

    // Idle for 10 cycles with stray pmem_resp pulses
    @(posedge clk);
    #1;
    bus.i_read = 1'b0;
    spurious   = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    spurious = 1'b0;
    check("idle_resp", bus.i_resp, 0);
    check("idle_pmem_read", bus.pmem_read, 0);
    check("idle_hit_count", bus.hit_count, exp_counter(32'd1));
    check("idle_miss_count", bus.miss_count, exp_counter(32'd1));
    fetch(32'h0000_0400, n);
    check("after_idle_hit", n, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Read-only, direct-mapped instruction cache between the CPU's aligned instruction channel (`i_addr`/`i_rdata`/`i_read`/`i_resp`) and a burst physical-memory port. Hits return a word in the same cycle. Misses fetch a 32-byte line as four 64-bit beats, install it, then return the word. This keeps the fetch stage fed without a shared-memory round trip on every instruction.

## Interface
- `NUM_SETS`, default 16: number of lines. Power of two, ≥2. `IDX_W = log2(NUM_SETS)`, `TAG_W = 27 - IDX_W`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. **One clock; reset is asynchronous and active-low.**
- `i_addr` in 32: fetch address. Bits [1:0] are ignored.
- `i_read` in 1: fetch request. The CPU may hold it high permanently.
- `i_rdata` out 32: instruction word. Valid only while `i_resp` = 1.
- `i_resp` out 1: word valid this cycle.
- `pmem_addr` out 32: line address, 32-byte aligned (bits [4:0] = 0).
- `pmem_read` out 1: burst read request.
- `pmem_rdata` in 64: burst beat data.
- `pmem_resp` in 1: beat valid. Exactly 4 beats per request.
- `hit_count` out 32: hit counter (only with ICACHE_PERF_CTR_EN).
- `miss_count` out 32: miss counter (only with ICACHE_PERF_CTR_EN).

## Operation
- Address split: tag = `i_addr[31:5+IDX_W]`, index = `i_addr[4+IDX_W:5]`, word = `i_addr[4:2]`.
- Storage is per-set flops, read asynchronously:
  - valid, 1 bit
  - tag, TAG_W bits
  - data, 256 bits; word w occupies bits [32w+31:32w].
- Three-state FSM:
  - IDLE
    - Hit (`i_read` & valid[idx] & tag match): `i_resp` = 1 combinationally; `i_rdata` = selected word.
    - Miss (`i_read` & not hit): latch the line address `{i_addr[31:5],5'b0}` into `pmem_addr`, go to FILL.
    - `i_read` = 0: `i_resp` = 0, no state change.
  - FILL
    - `pmem_read` = 1, `pmem_addr` held.
    - 2-bit beat counter starts at 0.
    - On each `pmem_resp`, beat k is written into buffer bits [64k+63:64k], then the counter increments.
    - On the 4th beat go to INSTALL.
    - `i_resp` = 0 throughout.
  - INSTALL (one cycle)
    - Write buffer, tag and valid = 1 into the set indexed by the latched address.
    - `pmem_read` = 0, `i_resp` = 0. Next state IDLE.
- A fill always completes and installs the latched line, even if `i_addr` changes or `i_read` drops mid-fill. On return to IDLE the current `i_addr` is looked up fresh; it may miss again.
- Replacement is direct-mapped: INSTALL overwrites whatever the set holds.
- No invalidate and no write path.

## Timing
- Reset (async assert, `rst` = 0):
  - all valid bits = 0, state = IDLE, beat counter = 0
  - `pmem_read` = 0, `pmem_addr` = 0
  - counters = 0
  - `i_resp` = 0 (no line is valid)
- Reset asserted mid-fill aborts the burst. `pmem_read` drops immediately. A partially filled line is never marked valid.
- Hit latency is 0 cycles: same cycle as the request.
- Miss: `pmem_read` rises the cycle after the miss is detected. Burst takes 4 `pmem_resp` cycles, plus 1 INSTALL cycle. The hit appears in the following IDLE cycle.
  - With back-to-back beats, `i_resp` comes 7 cycles after the miss cycle.
- `pmem_read` is held continuously from FILL entry until the 4th `pmem_resp`. It deasserts in INSTALL.
- `pmem_resp` outside FILL is ignored.
- Beat counter wraps 3→0 on the 4th beat.

## Configuration
- `ICACHE_PERF_CTR_EN` defined:
  - `hit_count` increments every cycle `i_resp` = 1.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both are 32-bit and wrap modulo 2^32.
- Not defined: both ports drive constant 0 and no counter flops exist.

## Test plan
- Cold miss:
  - Stimulus: after reset, `i_addr` = 0x0000_0064, `i_read` = 1; memory returns beats 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, 0x5555_5555_4444_4444, 0x7777_7777_6666_6666.
  - Required: `pmem_addr` = 0x0000_0060; then `i_resp` = 1 with `i_rdata` = 0x1111_1111 (word 1).
- Hit after fill: same line, `i_addr` = 0x0000_007C → same-cycle `i_resp` = 1, `i_rdata` = 0x7777_7777, no `pmem_read`.
- Conflict eviction (NUM_SETS = 16):
  - Stimulus: fetch 0x0000_0060, then 0x0000_0260 (same index), then 0x0000_0060 again.
  - Required: three bursts; `miss_count` = 3.
- Address change mid-fill: miss on 0x100, switch `i_addr` to 0x200 at beat 2 → line 0x100 installed, then a new burst to 0x200.
- Reset mid-fill: deassert `rst` low after beat 1 → `pmem_read` = 0 immediately; after release, the same address misses again.
- Idle: `i_read` = 0 for 10 cycles → `i_resp` = 0, `pmem_read` = 0, counters unchanged.
